// File: rtl/seq_frame_tx_3_1s_if.sv
// Handshake and serial-output bundle for the frame transmitter.
interface seq_frame_tx_3_1s_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load;
  logic             ready;
  logic             D_out;
  logic             En_out;
  logic             done;

  // Producer side: offers a word and watches the serial stream.
  modport master (
    output data_in,
    output load,
    input  ready,
    input  D_out,
    input  En_out,
    input  done
  );

  // Transmitter side.
  modport slave (
    input  data_in,
    input  load,
    output ready,
    output D_out,
    output En_out,
    output done
  );
endinterface

// File: rtl/seq_frame_tx_3_1s.sv
// Serial frame transmitter: emits sync 1,1,1, separator 0, then the payload
// LSB-first with a 0 stuffed after every pair of consecutive ones, so a
// "111" detector on D_out only ever fires on the sync marker.
// All state, including the serial outputs, advances on the falling edge.
module seq_frame_tx_3_1s #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  seq_frame_tx_3_1s_if.slave bus
);

  localparam int IW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    SEP   = 3'd2,
    DATA  = 3'd3,
    STUFF = 3'd4
  } state_t;

  // state_reg names the kind of bit currently on D_out; the output
  // registers are loaded together with the state so they line up exactly.
  state_t           state_reg, state_next;
  logic [1:0]       sync_cnt_reg, sync_cnt_next;
  logic [1:0]       ones_reg, ones_next;
  logic [IW-1:0]    idx_reg, idx_next;      // payload bits emitted so far
  logic [WIDTH-1:0] shift_reg, shift_next;  // bit 0 is the next payload bit
  logic             d_reg, d_next;
  logic             en_reg, en_next;
  logic             done_reg, done_next;
  logic             take_bit;

  assign bus.ready  = (state_reg == IDLE);
  assign bus.D_out  = d_reg;
  assign bus.En_out = en_reg;
  assign bus.done   = done_reg;

  // Next-state and next-output decode; a payload bit is emitted through the
  // shared take_bit path whether it follows SEP, DATA or STUFF.
  always_comb begin
    state_next    = state_reg;
    sync_cnt_next = sync_cnt_reg;
    ones_next     = ones_reg;
    idx_next      = idx_reg;
    shift_next    = shift_reg;
    d_next        = 1'b0;
    en_next       = 1'b0;
    done_next     = 1'b0;
    take_bit      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (bus.load) begin
          state_next    = SYNC;
          sync_cnt_next = 2'd0;
          ones_next     = 2'd0;
          idx_next      = '0;
          shift_next    = bus.data_in;
          d_next        = 1'b1;
          en_next       = 1'b1;
        end
      end
      SYNC: begin
        en_next = 1'b1;
        if (sync_cnt_reg == 2'd2) begin
          state_next    = SEP;
          sync_cnt_next = 2'd0;
          ones_next     = 2'd0;
          d_next        = 1'b0;
        end else begin
          sync_cnt_next = sync_cnt_reg + 2'd1;
          d_next        = 1'b1;
        end
      end
      SEP: begin
        take_bit = 1'b1;
      end
      DATA: begin
        if (ones_reg == 2'd2) begin
          // Break the run of ones; the index stays put during the stuff bit.
          state_next = STUFF;
          ones_next  = 2'd0;
          d_next     = 1'b0;
          en_next    = 1'b1;
          done_next  = (idx_reg == IW'(WIDTH));
        end else if (idx_reg == IW'(WIDTH)) begin
          state_next = IDLE;
        end else begin
          take_bit = 1'b1;
        end
      end
      STUFF: begin
        if (idx_reg == IW'(WIDTH)) begin
          state_next = IDLE;
        end else begin
          take_bit = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (take_bit) begin
      state_next = DATA;
      d_next     = shift_reg[0];
      en_next    = 1'b1;
      shift_next = shift_reg >> 1;
      idx_next   = idx_reg + IW'(1);
      ones_next  = shift_reg[0] ? (ones_reg + 2'd1) : 2'd0;
      // Last payload bit ends the frame unless it completes a pair of ones,
      // in which case the trailing stuff bit carries done instead.
      done_next  = (idx_reg + IW'(1) == IW'(WIDTH)) &&
                   !(shift_reg[0] && (ones_reg == 2'd1));
    end
  end

  // State and output registers, falling edge, synchronous reset first.
  always_ff @(negedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sync_cnt_reg <= 2'd0;
      ones_reg     <= 2'd0;
      idx_reg      <= '0;
      shift_reg    <= '0;
      d_reg        <= 1'b0;
      en_reg       <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sync_cnt_reg <= sync_cnt_next;
      ones_reg     <= ones_next;
      idx_reg      <= idx_next;
      shift_reg    <= shift_next;
      d_reg        <= d_next;
      en_reg       <= en_next;
      done_reg     <= done_next;
    end
  end

endmodule

// File: tb/tb_seq_frame_tx_3_1s.sv
// Self-checking bench for seq_frame_tx_3_1s. The DUT moves on the falling
// edge, so the bench drives and samples on the rising edge.
module tb_seq_frame_tx_3_1s;

  localparam int WIDTH = 8;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  seq_frame_tx_3_1s_if #(.WIDTH(WIDTH)) bus ();

  seq_frame_tx_3_1s #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected frame bits, built from the framing rules.
  bit exp_q[$];

  function automatic void build_frame(input logic [WIDTH-1:0] p);
    int ones;
    exp_q.delete();
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b1);
    exp_q.push_back(1'b0);
    ones = 0;
    for (int i = 0; i < WIDTH; i++) begin
      exp_q.push_back(p[i]);
      ones = p[i] ? ones + 1 : 0;
      if (ones == 2) begin
        exp_q.push_back(1'b0);
        ones = 0;
      end
    end
  endfunction

  // Loopback "111" detector, enabled by En_out, counts marker hits.
  bit det_on;
  int det_run;
  int det_fires;
  always @(posedge clk) begin
    if (!det_on) begin
      det_run   = 0;
      det_fires = 0;
    end else if (bus.En_out === 1'b1) begin
      if (bus.D_out === 1'b1) begin
        if (det_run == 2) det_fires++;
        if (det_run < 3) det_run++;
      end else begin
        det_run = 0;
      end
    end
  end

  task automatic test_reset();
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = '0;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      checks++;
      if ({bus.D_out, bus.En_out, bus.done, bus.ready} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_idle cycle %0d got D/En/done/ready=%b want 0001",
                 c, {bus.D_out, bus.En_out, bus.done, bus.ready});
      end
    end
    $display("reset: idle outputs checked over 6 cycles");
  endtask

  task automatic test_frame(input logic [WIDTH-1:0] p);
    int n;
    build_frame(p);
    n = exp_q.size();
    @(posedge clk);
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL frame_ready p=%h got %b want 1", p, bus.ready);
    end
    bus.data_in = p;
    bus.load    = 1'b1;
    @(posedge clk);
    bus.load    = 1'b0;
    bus.data_in = WIDTH'($urandom);
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(posedge clk);
      checks++;
      if ({bus.D_out, bus.En_out, bus.done, bus.ready} !==
          {exp_q[k], 1'b1, (k == n - 1), 1'b0}) begin
        errors++;
        $display("FAIL frame_bit p=%h bit %0d got D/En/done/ready=%b want %b",
                 p, k, {bus.D_out, bus.En_out, bus.done, bus.ready},
                 {exp_q[k], 1'b1, (k == n - 1), 1'b0});
      end
    end
    @(posedge clk);
    checks++;
    if ({bus.D_out, bus.En_out, bus.done, bus.ready} !== 4'b0001) begin
      errors++;
      $display("FAIL frame_after p=%h got D/En/done/ready=%b want 0001",
               p, {bus.D_out, bus.En_out, bus.done, bus.ready});
    end
    $display("frame p=%h len=%0d errors=%0d", p, n, errors);
  endtask

  task automatic test_reset_midframe();
    build_frame(8'hFF);
    @(posedge clk);
    bus.data_in = 8'hFF;
    bus.load    = 1'b1;
    @(posedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(posedge clk);
      checks++;
      if ({bus.D_out, bus.En_out} !== {exp_q[k], 1'b1}) begin
        errors++;
        $display("FAIL midframe_bit %0d got D/En=%b want %b",
                 k, {bus.D_out, bus.En_out}, {exp_q[k], 1'b1});
      end
    end
    reset = 1'b1;
    @(posedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({bus.D_out, bus.En_out, bus.done, bus.ready} !== 4'b0001) begin
        errors++;
        $display("FAIL midframe_abort cycle %0d got D/En/done/ready=%b want 0001",
                 c, {bus.D_out, bus.En_out, bus.done, bus.ready});
      end
      @(posedge clk);
    end
    $display("reset mid-frame: abort checked, errors=%0d", errors);
    test_frame(8'hA5);
  endtask

  task automatic test_busy();
    int n;
    build_frame(8'hA5);
    n = exp_q.size();
    @(posedge clk);
    bus.data_in = 8'hA5;
    bus.load    = 1'b1;
    @(posedge clk);
    bus.load = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (k > 0) @(posedge clk);
      if (k == 4) begin
        bus.load    = 1'b1;
        bus.data_in = 8'hFF;
      end else begin
        bus.load = 1'b0;
      end
      checks++;
      if ({bus.D_out, bus.En_out, bus.done} !== {exp_q[k], 1'b1, (k == n - 1)}) begin
        errors++;
        $display("FAIL busy_bit %0d got D/En/done=%b want %b",
                 k, {bus.D_out, bus.En_out, bus.done}, {exp_q[k], 1'b1, (k == n - 1)});
      end
    end
    bus.load = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      checks++;
      if ({bus.En_out, bus.ready} !== 2'b01) begin
        errors++;
        $display("FAIL busy_not_queued cycle %0d got En/ready=%b want 01",
                 c, {bus.En_out, bus.ready});
      end
    end
    $display("busy load ignored: errors=%0d", errors);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] pl [3];
    int n;
    pl[0] = 8'h00;
    pl[1] = 8'hFF;
    pl[2] = 8'hA5;
    det_on = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus.data_in = pl[0];
    bus.load    = 1'b1;
    for (int f = 0; f < 3; f++) begin
      build_frame(pl[f]);
      n = exp_q.size();
      @(posedge clk);
      bus.load = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (k > 0) @(posedge clk);
        checks++;
        if ({bus.D_out, bus.En_out, bus.done, bus.ready} !==
            {exp_q[k], 1'b1, (k == n - 1), 1'b0}) begin
          errors++;
          $display("FAIL b2b_bit frame %0d bit %0d got D/En/done/ready=%b want %b",
                   f, k, {bus.D_out, bus.En_out, bus.done, bus.ready},
                   {exp_q[k], 1'b1, (k == n - 1), 1'b0});
        end
      end
      @(posedge clk);
      checks++;
      if ({bus.En_out, bus.ready} !== 2'b01) begin
        errors++;
        $display("FAIL b2b_gap frame %0d got En/ready=%b want 01",
                 f, {bus.En_out, bus.ready});
      end
      if (f < 2) begin
        bus.data_in = pl[f + 1];
        bus.load    = 1'b1;
      end
      $display("b2b frame %0d p=%h len=%0d errors=%0d", f, pl[f], n, errors);
    end
    @(posedge clk);
    @(posedge clk);
    checks++;
    if (det_fires != 3) begin
      errors++;
      $display("FAIL loopback_detect got %0d hits want 3", det_fires);
    end
    det_on = 1'b0;
    $display("loopback detector hits=%0d", det_fires);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      test_frame(WIDTH'($urandom));
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    det_on      = 1'b0;
    reset       = 1'b1;
    bus.load    = 1'b0;
    bus.data_in = '0;
    test_reset();
    test_frame(8'hA5);
    test_frame(8'hFF);
    test_frame(8'h03);
    test_frame(8'hC0);
    test_frame(8'h00);
    test_reset_midframe();
    test_busy();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
